// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI word bridge.
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_CLEAR,
    ST_WAIT_LOW
  } bridge_state_t;

  // Depth of the slave-side synchronizer feeding the flag and data.
  localparam int unsigned SYNC_DEPTH = 2;

  // Minimum clk cycles between two words the bridge can accept.
  function automatic int unsigned min_word_gap(input int unsigned clear_cycles);
    return 3 + clear_cycles + SYNC_DEPTH;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head is read combinationally.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  // Next-pointer arithmetic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/spi_word_bridge.sv
// Bridges the SPI slave's new-word flag/data to valid/ready streams for the sort core.
module spi_word_bridge
  import spi_bridge_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 16,
  parameter int unsigned           RX_DEPTH     = 8,
  parameter int unsigned           TX_DEPTH     = 8,
  parameter int unsigned           CLEAR_CYCLES = 3,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE_WORD = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  synced_new_data_flag,
  input  logic [DATA_WIDTH-1:0] synced_data_received,
  output logic                  clear_new_data_flag,
  output logic [DATA_WIDTH-1:0] data_to_send,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  rx_overflow,
  output logic [15:0]           word_count
);

  localparam int unsigned CNT_W = $clog2(CLEAR_CYCLES + 1);

  bridge_state_t         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  flag_q;
  logic                  clear_q, clear_d;
  logic [DATA_WIDTH-1:0] dts_q, dts_d;
  logic                  ovf_q, ovf_d;
  logic [15:0]           wc_q, wc_d;
  logic                  capture, flag_edge;
  logic                  rx_full, rx_empty;
  logic                  tx_full, tx_empty;
  logic [DATA_WIDTH-1:0] tx_head;

  assign flag_edge = synced_new_data_flag & ~flag_q;

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (capture),
    .pop     (rx_ready),
    .wr_data (synced_data_received),
    .head    (rx_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_valid & ~tx_full),
    .pop     (capture),
    .wr_data (tx_data),
    .head    (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  assign rx_valid            = ~rx_empty;
  assign tx_ready            = ~tx_full;
  assign clear_new_data_flag = clear_q;
  assign data_to_send        = dts_q;
  assign rx_overflow         = ovf_q;
  assign word_count          = wc_q;

  // Next-state logic; clear is registered from the next state so it is glitch-free.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      ST_FLUSH, ST_CLEAR: begin
        if (cnt_q == CNT_W'(CLEAR_CYCLES - 1)) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE:     if (flag_edge) state_d = ST_SETTLE;
      ST_SETTLE:   state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        capture = 1'b1;
        state_d = ST_CLEAR;
      end
      ST_WAIT_LOW: if (!synced_new_data_flag) state_d = ST_IDLE;
      default:     state_d = ST_FLUSH;
    endcase
    clear_d = (state_d == ST_FLUSH) || (state_d == ST_CLEAR);
  end

  // Capture-side datapath updates.
  always_comb begin
    dts_d = dts_q;
    ovf_d = ovf_q;
    wc_d  = wc_q;
    if (capture) begin
      dts_d = tx_empty ? TX_IDLE_WORD : tx_head;
      wc_d  = wc_q + 16'd1;
      if (rx_full && !rx_ready) ovf_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FLUSH;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      clear_q <= 1'b1;
      dts_q   <= TX_IDLE_WORD;
      ovf_q   <= 1'b0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= synced_new_data_flag;
      clear_q <= clear_d;
      dts_q   <= dts_d;
      ovf_q   <= ovf_d;
      wc_q    <= wc_d;
    end
  end

endmodule
